// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if: redirect, imem and decode handshake bundle.
// master = fetch stage side, slave = core/memory/decode side.
interface fetch_pipe_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        i_pcsrc;
  logic [ADDR_W-1:0] i_execute;
  logic [ADDR_W-1:0] i_epc_to_pc;
  logic [ADDR_W-1:0] i_error_handler;
  logic              o_imem_req;
  logic [ADDR_W-1:0] o_imem_addr;
  logic [DATA_W-1:0] i_imem_rdata;
  logic              o_fetch_valid;
  logic              i_decode_ready;
  logic [ADDR_W-1:0] o_fetch_pc;
  logic [DATA_W-1:0] o_fetch_instr;
  logic              o_misalign;

  modport master (
    input  i_pcsrc, i_execute,
    input  i_epc_to_pc, i_error_handler,
    input  i_imem_rdata, i_decode_ready,
    output o_imem_req, o_imem_addr,
    output o_fetch_valid, o_fetch_pc,
    output o_fetch_instr, o_misalign
  );

  modport slave (
    output i_pcsrc, i_execute,
    output i_epc_to_pc, i_error_handler,
    output i_imem_rdata, i_decode_ready,
    input  o_imem_req, o_imem_addr,
    input  o_fetch_valid, o_fetch_pc,
    input  o_fetch_instr, o_misalign
  );
endinterface

// File: rtl/fetch_pipe.sv
// fetch_pipe: PC, 1-cycle imem issue, fetch FIFO, redirects.
// Ports: i_clk, i_rst_n (async low), bus (fetch_pipe_if.master).
module fetch_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_pipe_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEP_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic              infl_q, infl_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] fpc_q [DEPTH];
  logic [DATA_W-1:0] fin_q [DEPTH];

  logic              redir;
  logic              req;
  logic              vld;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] tgt;

  always_comb begin
    redir = bus.i_pcsrc != 2'b00;
    tgt   = bus.i_execute;
    unique case (bus.i_pcsrc)
      2'b10:   tgt = bus.i_epc_to_pc + FOUR;
      2'b11:   tgt = bus.i_error_handler;
      default: tgt = bus.i_execute;
    endcase
    // credit: pending response counts as occupied
    req  = i_rst_n && !redir &&
           ((cnt_q + CW'(infl_q)) < DEP_C);
    vld  = (cnt_q != '0) && !redir;
    pop  = vld && bus.i_decode_ready;
    push = infl_q && !redir;
  end

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    infl_d = 1'b0;
    cnt_d  = cnt_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    mis_d  = 1'b0;
    if (redir) begin
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
      if (tgt[1:0] != 2'b00 &&
          bus.i_pcsrc != 2'b11) begin
        pc_d  = bus.i_error_handler;
        mis_d = 1'b1;
      end else begin
        pc_d = tgt;
      end
    end else begin
      if (req) begin
        pc_d   = pc_q + FOUR;
        rpc_d  = pc_q;
        infl_d = 1'b1;
      end
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q   <= RESET_PC;
      rpc_q  <= '0;
      infl_q <= 1'b0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      mis_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      mis_q  <= mis_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fpc_q[i] <= '0;
        fin_q[i] <= '0;
      end
    end else if (push) begin
      fpc_q[wp_q] <= rpc_q;
      fin_q[wp_q] <= bus.i_imem_rdata;
    end
  end

  assign bus.o_imem_req    = req;
  assign bus.o_imem_addr   = pc_q;
  assign bus.o_fetch_valid = vld;
  assign bus.o_fetch_pc    = fpc_q[rp_q];
  assign bus.o_fetch_instr = fin_q[rp_q];
  assign bus.o_misalign    = mis_q;
endmodule

// File: tb/tb_fetch_pipe.sv
// tb_fetch_pipe: directed checks of fetch_pipe.
// Two instances: 32-bit main, 8-bit for PC wrap.
module tb_fetch_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fetch_pipe_if #(.ADDR_W(32), .DATA_W(32)) b ();
  fetch_pipe_if #(.ADDR_W(8), .DATA_W(32)) b2 ();

  fetch_pipe #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b)
  );

  fetch_pipe #(
    .ADDR_W(8), .DATA_W(32), .DEPTH(4),
    .RESET_PC(8'hF8)
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst2_n), .bus(b2)
  );

  function automatic logic [31:0] f32(
    input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] f8(
    input logic [7:0] a);
    return {24'h0, a} ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk)
    if (b.o_imem_req)
      b.i_imem_rdata <= f32(b.o_imem_addr);

  always @(posedge clk)
    if (b2.o_imem_req)
      b2.i_imem_rdata <= f8(b2.o_imem_addr);

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs=%0h exp=%0h",
                tag, obs, exp);
  endtask

  task automatic step(input logic rdy,
                      input logic [1:0] src);
    @(negedge clk);
    b.i_decode_ready = rdy;
    b.i_pcsrc = src;
    #1;
  endtask

  task automatic release_rst(input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    b.i_pcsrc = 2'b00;
    b.i_decode_ready = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic head(input string tag,
                      input logic [31:0] pc);
    chk({tag, "_vld"}, b.o_fetch_valid, 1);
    chk({tag, "_pc"}, b.o_fetch_pc, pc);
    chk({tag, "_ins"}, b.o_fetch_instr, f32(pc));
  endtask

  initial begin
    b.i_pcsrc = 2'b00;
    b.i_execute = 32'h0;
    b.i_epc_to_pc = 32'h0;
    b.i_error_handler = 32'h180;
    b.i_decode_ready = 1'b1;
    b.i_imem_rdata = 32'h0;
    b2.i_pcsrc = 2'b00;
    b2.i_execute = 8'h0;
    b2.i_epc_to_pc = 8'h0;
    b2.i_error_handler = 8'h0;
    b2.i_decode_ready = 1'b1;
    b2.i_imem_rdata = 32'h0;

    // reset state
    @(negedge clk);
    #1;
    chk("rst_req", b.o_imem_req, 0);
    chk("rst_vld", b.o_fetch_valid, 0);
    chk("rst_mis", b.o_misalign, 0);
    chk("rst_addr", b.o_imem_addr, 0);
    chk("rst_pc", b.o_fetch_pc, 0);
    chk("rst_ins", b.o_fetch_instr, 0);

    // streaming, ready high
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s0_req", b.o_imem_req, 1);
    chk("s0_addr", b.o_imem_addr, 0);
    chk("s0_vld", b.o_fetch_valid, 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 2'b00);
      chk("s_req", b.o_imem_req, 1);
      chk("s_addr", b.o_imem_addr, 4 * k);
      if (k < 2) chk("s_vld", b.o_fetch_valid, 0);
      else head("s_head", 32'(4 * (k - 2)));
    end

    // async reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("ar_req", b.o_imem_req, 0);
    chk("ar_vld", b.o_fetch_valid, 0);
    chk("ar_addr", b.o_imem_addr, 0);
    chk("ar_pc", b.o_fetch_pc, 0);
    chk("ar_ins", b.o_fetch_instr, 0);

    // decode stall, fill to DEPTH
    release_rst(1'b0);
    chk("st0_addr", b.o_imem_addr, 0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 2'b00);
      chk("st_req", b.o_imem_req, k <= 3);
      chk("st_addr", b.o_imem_addr,
          k <= 3 ? 4 * k : 16);
      if (k >= 2) head("st_head", 0);
    end
    for (int j = 0; j <= 5; j++) begin
      step(1'b1, 2'b00);
      head("dr_head", 32'(4 * j));
      chk("dr_req", b.o_imem_req, j != 0);
      if (j != 0)
        chk("dr_addr", b.o_imem_addr,
            16 + 4 * (j - 1));
    end

    // redirect with 3 buffered entries
    release_rst(1'b0);
    for (int k = 1; k <= 3; k++) step(1'b0, 2'b00);
    b.i_execute = 32'h100;
    step(1'b1, 2'b01);
    chk("rd_vld", b.o_fetch_valid, 0);
    chk("rd_req", b.o_imem_req, 0);
    step(1'b1, 2'b00);
    chk("rd1_addr", b.o_imem_addr, 32'h100);
    chk("rd1_req", b.o_imem_req, 1);
    chk("rd1_vld", b.o_fetch_valid, 0);
    chk("rd1_mis", b.o_misalign, 0);
    step(1'b1, 2'b00);
    chk("rd2_vld", b.o_fetch_valid, 0);
    step(1'b1, 2'b00);
    head("rd3", 32'h100);
    step(1'b1, 2'b00);
    head("rd4", 32'h104);

    // EPC+4 redirect
    b.i_epc_to_pc = 32'h40;
    step(1'b1, 2'b10);
    chk("ep_vld", b.o_fetch_valid, 0);
    step(1'b1, 2'b00);
    chk("ep_addr", b.o_imem_addr, 32'h44);
    chk("ep_mis", b.o_misalign, 0);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    head("ep3", 32'h44);

    // back-to-back: execute then handler
    b.i_execute = 32'h200;
    step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    chk("bb_addr", b.o_imem_addr, 32'h180);
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    head("bb3", 32'h180);

    // misaligned execute target
    b.i_execute = 32'h102;
    step(1'b1, 2'b01);
    chk("ma0_mis", b.o_misalign, 0);
    step(1'b1, 2'b00);
    chk("ma1_mis", b.o_misalign, 1);
    chk("ma1_addr", b.o_imem_addr, 32'h180);
    step(1'b1, 2'b00);
    chk("ma2_mis", b.o_misalign, 0);
    chk("ma2_addr", b.o_imem_addr, 32'h184);
    step(1'b1, 2'b00);
    head("ma3", 32'h180);

    // 8-bit PC wrap
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("w0_addr", b2.o_imem_addr, 8'hF8);
    step(1'b1, 2'b00);
    chk("w1_addr", b2.o_imem_addr, 8'hFC);
    step(1'b1, 2'b00);
    chk("w2_addr", b2.o_imem_addr, 8'h00);
    chk("w2_pc", b2.o_fetch_pc, 8'hF8);
    step(1'b1, 2'b00);
    chk("w3_addr", b2.o_imem_addr, 8'h04);
    chk("w3_pc", b2.o_fetch_pc, 8'hFC);
    step(1'b1, 2'b00);
    chk("w4_vld", b2.o_fetch_valid, 1);
    chk("w4_pc", b2.o_fetch_pc, 8'h00);
    chk("w4_ins", b2.o_fetch_instr, f8(8'h00));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
